// File: rtl/core_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : core_run_ctrl_pkg
// Brief    : State encoding and CFG/CSR field positions for the run sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package core_run_ctrl_pkg;

    localparam int c_state_w = 3;

    localparam logic [c_state_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_state_w-1:0] c_st_launch = 3'd1;
    localparam logic [c_state_w-1:0] c_st_wait   = 3'd2;
    localparam logic [c_state_w-1:0] c_st_gap    = 3'd3;
    localparam logic [c_state_w-1:0] c_st_abort  = 3'd4;

    localparam int c_cfg1_start  = 0;
    localparam int c_cfg1_abort  = 1;
    localparam int c_cfg1_cont   = 2;
    localparam int c_cfg1_irq_en = 3;
    localparam int c_cfg1_n_lsb  = 32;
    localparam int c_cfg1_n_msb  = 47;
    localparam int c_cfg2_tmo_msb = 31;
    localparam int c_cfg3_gap_msb = 15;

    localparam int c_csr_state_lsb = 0;
    localparam int c_csr_state_msb = 2;
    localparam int c_csr_busy      = 3;
    localparam int c_csr_done      = 4;
    localparam int c_csr_tmo       = 5;
    localparam int c_csr_err       = 6;
    localparam int c_csr_abt       = 7;
    localparam int c_csr_iter_lsb  = 32;
    localparam int c_csr_iter_msb  = 47;

    typedef struct packed {
        logic aborted;
        logic error;
        logic timeout;
        logic done;
    } sticky_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_run_timer.sv
`default_nettype none
// ============================================================================
// Module   : core_run_timer
// Brief    : Loadable up/down counter with zero flag; load wins over enable.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_timer #(
    parameter int WIDTH = 32
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_run_ctrl
// Brief    : Run sequencer: launches core iterations, handles gap, timeout,
//            abort and soft reset, and builds the CORE_CSR0 status word.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int C_S_AXI_REG_DWIDTH = 64,
    parameter int RST_CYCLES         = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_REG_DWIDTH-1:0] CORE_CFG1,
    input  logic [C_S_AXI_REG_DWIDTH-1:0] CORE_CFG2,
    input  logic [C_S_AXI_REG_DWIDTH-1:0] CORE_CFG3,
    output logic [C_S_AXI_REG_DWIDTH-1:0] CORE_CSR0,
    output logic                          core_start,
    output logic                          core_soft_rst,
    input  logic                          core_done,
    input  logic                          core_error,
    output logic                          irq
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;
    logic                 r_start_q;
    logic [15:0]          r_n;
    logic [31:0]          r_tmo;
    logic [15:0]          r_gap;
    logic                 r_cont;
    logic [15:0]          r_iter;
    logic [15:0]          w_iter_next;
    logic [15:0]          w_iter_inc;
    sticky_t              r_sticky;
    sticky_t              w_sticky_next;
    logic [63:0]          r_csr0;
    logic [63:0]          w_csr0;
    logic                 r_irq;
    logic                 w_edge;
    logic                 w_last;
    logic                 w_run_state;

    logic        w_tmr_load;
    logic [31:0] w_tmr_val;
    logic        w_tmr_en;
    logic        w_tmr_up;
    logic [31:0] w_tmr_count;
    logic        w_tmr_zero;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{CORE_CFG1[63:48], CORE_CFG1[31:4],
                            CORE_CFG2[63:32], CORE_CFG3[63:16]};

    assign w_edge      = CORE_CFG1[c_cfg1_start] & ~r_start_q;
    assign w_iter_inc  = sat_inc16(r_iter);
    assign w_last      = (w_iter_inc == r_n);
    assign w_run_state = (r_state == c_st_launch) || (r_state == c_st_wait) ||
                         (r_state == c_st_gap);

    always_comb begin
        w_next        = r_state;
        w_sticky_next = r_sticky;
        w_iter_next   = r_iter;
        case (r_state)
            c_st_idle: begin
                if (w_edge) begin
                    w_next        = c_st_launch;
                    w_sticky_next = '0;
                    w_iter_next   = '0;
                end
            end
            c_st_launch: w_next = c_st_wait;
            c_st_wait: begin
                if (core_error) begin
                    w_next              = c_st_idle;
                    w_sticky_next.error = 1'b1;
                end else if (core_done) begin
                    // Start is sampled live here so a continuous run can be stopped cleanly.
                    if ((w_last && !r_cont) || !CORE_CFG1[c_cfg1_start]) begin
                        w_next             = c_st_idle;
                        w_sticky_next.done = 1'b1;
                        w_iter_next        = w_iter_inc;
                    end else begin
                        w_iter_next = w_last ? 16'd0 : w_iter_inc;
                        w_next      = (r_gap == 16'd0) ? c_st_launch : c_st_gap;
                    end
                end else if ((r_tmo != 32'd0) && (w_tmr_count + 32'd1 == r_tmo)) begin
                    w_next                = c_st_abort;
                    w_sticky_next.timeout = 1'b1;
                end
            end
            c_st_gap:   if (w_tmr_zero) w_next = c_st_launch;
            c_st_abort: if (w_tmr_zero) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase

        if (CORE_CFG1[c_cfg1_abort] && w_run_state) begin
            w_next                = c_st_abort;
            w_sticky_next         = r_sticky;
            w_sticky_next.aborted = 1'b1;
            w_iter_next           = r_iter;
            if ((r_state == c_st_wait) && core_error) w_sticky_next.error = 1'b1;
        end
    end

    // One timer serves WAIT (counts up from 0), GAP and ABORT (count down to zero).
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = 32'd0;
        w_tmr_en   = 1'b0;
        w_tmr_up   = 1'b0;
        case (r_state)
            c_st_launch: w_tmr_load = 1'b1;
            c_st_wait: begin
                w_tmr_en = 1'b1;
                w_tmr_up = 1'b1;
            end
            c_st_gap, c_st_abort: w_tmr_en = 1'b1;
            default: ;
        endcase
        if ((w_next == c_st_gap) && (r_state != c_st_gap)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = 32'(r_gap) - 32'd1;
        end
        if ((w_next == c_st_abort) && (r_state != c_st_abort)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = 32'(RST_CYCLES - 1);
        end
    end

    core_run_timer #(
        .WIDTH (32)
    ) u_timer (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .i_load        (w_tmr_load),
        .i_load_val    (w_tmr_val),
        .i_en          (w_tmr_en),
        .i_up          (w_tmr_up),
        .o_count       (w_tmr_count),
        .o_zero        (w_tmr_zero)
    );

    always_comb begin
        w_csr0 = '0;
        w_csr0[c_csr_state_msb:c_csr_state_lsb] = r_state;
        w_csr0[c_csr_busy]                      = (r_state != c_st_idle);
        w_csr0[c_csr_done]                      = r_sticky.done;
        w_csr0[c_csr_tmo]                       = r_sticky.timeout;
        w_csr0[c_csr_err]                       = r_sticky.error;
        w_csr0[c_csr_abt]                       = r_sticky.aborted;
        w_csr0[c_csr_iter_msb:c_csr_iter_lsb]   = r_iter;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= c_st_idle;
            r_start_q <= 1'b0;
            r_n       <= '0;
            r_tmo     <= '0;
            r_gap     <= '0;
            r_cont    <= 1'b0;
            r_iter    <= '0;
            r_sticky  <= '0;
            r_csr0    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_start_q <= CORE_CFG1[c_cfg1_start];
            r_state   <= w_next;
            r_sticky  <= w_sticky_next;
            r_iter    <= w_iter_next;
            if ((r_state == c_st_idle) && w_edge) begin
                r_n    <= (CORE_CFG1[c_cfg1_n_msb:c_cfg1_n_lsb] == 16'd0) ? 16'd1
                          : CORE_CFG1[c_cfg1_n_msb:c_cfg1_n_lsb];
                r_tmo  <= CORE_CFG2[c_cfg2_tmo_msb:0];
                r_gap  <= CORE_CFG3[c_cfg3_gap_msb:0];
                r_cont <= CORE_CFG1[c_cfg1_cont];
            end
            r_csr0 <= w_csr0;
            r_irq  <= CORE_CFG1[c_cfg1_irq_en] & (|r_sticky);
        end
    end

    assign CORE_CSR0     = r_csr0;
    assign irq           = r_irq;
    assign core_start    = (r_state == c_st_launch);
    assign core_soft_rst = (r_state == c_st_abort);

endmodule
`default_nettype wire
